// File: rtl/hawk_beacon_sequencer.sv
// hawk_beacon_sequencer: pedestrian hybrid beacon (HAWK) lamp sequencer.
// Walks DARK -> FLASH_Y -> STEADY_Y -> STEADY_R -> ALT_R -> RECOVER under a
// tick time base, latching pedestrian requests and driving registered lamps.
// Optional build macro HAWK_COUNTDOWN_EN: when defined, countdown reports the
// remaining clearance ticks during ALT_R; otherwise countdown is tied to 0.
// Handshake note: there is no valid/ready traffic here; ped_btn is a level
// sampled every clk and tick is a one-clk-wide enable pulse.
module hawk_beacon_sequencer #(
    parameter int T_FY   = 4,
    parameter int T_SY   = 3,
    parameter int T_WALK = 7,
    parameter int T_CLR  = 10,
    parameter int T_REC  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_btn,
    output logic       y_lamp,
    output logic       r_left,
    output logic       r_right,
    output logic       walk,
    output logic       dnw,
    output logic       busy,
    output logic       req_pending,
    output logic [4:0] countdown,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_DARK     = 3'd0,
        S_FLASH_Y  = 3'd1,
        S_STEADY_Y = 3'd2,
        S_STEADY_R = 3'd3,
        S_ALT_R    = 3'd4,
        S_RECOVER  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] timer_q, timer_d;
    logic       flash_q, flash_d;
    logic       req_q, req_d;
    logic       y_q, y_d, rl_q, rl_d, rr_q, rr_d;
    logic       walk_q, walk_d, dnw_q, dnw_d, busy_q, busy_d;
    logic       load;

    // Next-state, timer, flash phase and request latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        flash_d = flash_q;
        load    = 1'b0;
        // Presses count only while the crossing is not already being announced.
        req_d   = req_q | (ped_btn & ((state_q == S_DARK) || (state_q == S_STEADY_R) ||
                                      (state_q == S_ALT_R) || (state_q == S_RECOVER)));
        case (state_q)
            S_DARK: begin
                if (tick && req_d) begin
                    state_d = S_FLASH_Y;
                    load    = 1'b1;
                end
            end
            S_FLASH_Y, S_STEADY_Y, S_STEADY_R, S_ALT_R, S_RECOVER: begin
                if (tick) begin
                    if (timer_q == 5'd1) begin
                        load = 1'b1;
                        case (state_q)
                            S_FLASH_Y:  state_d = S_STEADY_Y;
                            S_STEADY_Y: state_d = S_STEADY_R;
                            S_STEADY_R: state_d = S_ALT_R;
                            S_ALT_R:    state_d = S_RECOVER;
                            default:    state_d = req_d ? S_FLASH_Y : S_DARK;
                        endcase
                    end else begin
                        timer_d = timer_q - 5'd1;
                        flash_d = ~flash_q;
                    end
                end
            end
            default: begin
                state_d = S_DARK;
                timer_d = 5'd0;
                flash_d = 1'b0;
            end
        endcase
        // Entry actions: load the new state's duration and restart the flash phase.
        if (load) begin
            case (state_d)
                S_FLASH_Y: begin
                    timer_d = 5'(T_FY);
                    flash_d = 1'b1;
                    req_d   = 1'b0;
                end
                S_STEADY_Y: timer_d = 5'(T_SY);
                S_STEADY_R: timer_d = 5'(T_WALK);
                S_ALT_R: begin
                    timer_d = 5'(T_CLR);
                    flash_d = 1'b1;
                end
                S_RECOVER: timer_d = 5'(T_REC);
                default: begin
                    timer_d = 5'd0;
                    flash_d = 1'b0;
                end
            endcase
        end
    end

    // Lamp decode from the upcoming state so outputs land with the state register.
    always_comb begin
        y_d    = 1'b0;
        rl_d   = 1'b0;
        rr_d   = 1'b0;
        walk_d = 1'b0;
        dnw_d  = 1'b1;
        busy_d = (state_d != S_DARK);
        case (state_d)
            S_FLASH_Y:  y_d = flash_d;
            S_STEADY_Y: y_d = 1'b1;
            S_STEADY_R: begin
                rl_d   = 1'b1;
                rr_d   = 1'b1;
                walk_d = 1'b1;
                dnw_d  = 1'b0;
            end
            S_ALT_R: begin
                rl_d  = flash_d;
                rr_d  = ~flash_d;
                dnw_d = flash_d;
            end
            default: ;
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_DARK;
            timer_q <= 5'd0;
            flash_q <= 1'b0;
            req_q   <= 1'b0;
            y_q     <= 1'b0;
            rl_q    <= 1'b0;
            rr_q    <= 1'b0;
            walk_q  <= 1'b0;
            dnw_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            flash_q <= flash_d;
            req_q   <= req_d;
            y_q     <= y_d;
            rl_q    <= rl_d;
            rr_q    <= rr_d;
            walk_q  <= walk_d;
            dnw_q   <= dnw_d;
            busy_q  <= busy_d;
        end
    end

`ifdef HAWK_COUNTDOWN_EN
    logic [4:0] countdown_q, countdown_d;

    // Clearance countdown mirrors the timer only while the reds alternate.
    always_comb begin
        countdown_d = (state_d == S_ALT_R) ? timer_d : 5'd0;
    end

    // Countdown register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) countdown_q <= 5'd0;
        else        countdown_q <= countdown_d;
    end

    assign countdown = countdown_q;
`else
    assign countdown = 5'd0;
`endif

    assign y_lamp      = y_q;
    assign r_left      = rl_q;
    assign r_right     = rr_q;
    assign walk        = walk_q;
    assign dnw         = dnw_q;
    assign busy        = busy_q;
    assign req_pending = req_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hawk_beacon_sequencer.sv
// tb_hawk_beacon_sequencer: self-checking bench for hawk_beacon_sequencer.
// Reference model tracks phase index, ticks left and ticks elapsed in phase.
module tb_hawk_beacon_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       ped_btn = 1'b0;
    logic       y_lamp, r_left, r_right, walk, dnw, busy, req_pending;
    logic [4:0] countdown;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase durations in ticks, indexed by phase number.
    int dur [6] = '{0, 4, 3, 7, 10, 20};
    int m_st   = 0;
    int m_left = 0;
    int m_ph   = 0;
    bit m_req  = 1'b0;

    hawk_beacon_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .ped_btn(ped_btn),
        .y_lamp(y_lamp), .r_left(r_left), .r_right(r_right), .walk(walk),
        .dnw(dnw), .busy(busy), .req_pending(req_pending),
        .countdown(countdown), .state(state)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    function automatic void m_enter(input int s);
        m_st   = s;
        m_ph   = 0;
        m_left = dur[s];
        if (s == 1) m_req = 1'b0;
    endfunction

    function automatic void m_reset();
        m_st = 0; m_left = 0; m_ph = 0; m_req = 1'b0;
    endfunction

    // One clk of the model with the inputs present before the edge.
    function automatic void model_step(input logic t, input logic b);
        if (b && (m_st == 0 || m_st >= 3)) m_req = 1'b1;
        if (m_st == 0) begin
            if (t && m_req) m_enter(1);
        end else if (t) begin
            if (m_left == 1) begin
                if (m_st == 5) m_enter(m_req ? 1 : 0);
                else           m_enter(m_st + 1);
            end else begin
                m_left--;
                m_ph++;
            end
        end
    endfunction

    // Expected {state, y, rl, rr, walk, dnw, busy, req, countdown}.
    function automatic logic [14:0] exp_vec();
        logic fl;
        logic y, rl, rr, w, d;
        logic [4:0] cd;
        fl = ((m_ph % 2) == 0);
        y = 0; rl = 0; rr = 0; w = 0; d = 1; cd = 5'd0;
        case (m_st)
            1: y = fl;
            2: y = 1'b1;
            3: begin rl = 1; rr = 1; w = 1; d = 0; end
            4: begin rl = fl; rr = !fl; d = fl; end
            default: ;
        endcase
`ifdef HAWK_COUNTDOWN_EN
        if (m_st == 4) cd = 5'(m_left);
`endif
        return {3'(m_st), y, rl, rr, w, d, (m_st != 0), m_req, cd};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {state, y_lamp, r_left, r_right, walk, dnw, busy, req_pending, countdown};
    endfunction

    // Driver: present inputs at negedge, advance model, sample #1 after posedge.
    task automatic step(input logic t, input logic b);
        @(negedge clk);
        tick = t;
        ped_btn = b;
        model_step(t, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_state got %h exp %h", obs_vec(), exp_vec());
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_press();
        int busy_ticks;
        logic [3:0] yv;
        logic [2:0] pre;
        busy_ticks = 0;
        yv = 4'b0;
        step(1'b0, 1'b1);
        checks++;
        if (req_pending !== 1'b1) begin
            errors++;
            $display("FAIL press_latch got %b exp 1", req_pending);
        end
        for (int i = 0; i < 46 * 4; i++) begin
            logic t;
            t = ((i % 4) == 3);
            pre = state;
            if (t && pre != 3'd0) busy_ticks++;
            if (t && pre == 3'd1) yv = {yv[2:0], y_lamp};
            step(t, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_seq t=%0t got %h exp %h", $time, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (busy_ticks != 44) begin
            errors++;
            $display("FAIL seq_length got %0d exp 44", busy_ticks);
        end
        checks++;
        if (yv !== 4'b1010) begin
            errors++;
            $display("FAIL flash_yellow got %b exp 1010", yv);
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL end_dark got %0d exp 0", state);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b1);
        checks++;
        if (state !== 3'd1 || req_pending !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle got st=%0d req=%b exp st=1 req=0", state, req_pending);
        end
        for (int i = 0; i < 46 * 4; i++) begin
            step(((i % 4) == 3), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL same_cycle_seq t=%0t got %h exp %h", $time, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_press_steady_r();
        bit pressed;
        bit first_exit_seen;
        logic [2:0] pre;
        logic [2:0] first_exit;
        pressed = 0;
        first_exit_seen = 0;
        first_exit = 3'd7;
        step(1'b0, 1'b1);
        for (int i = 0; i < 100 * 4; i++) begin
            logic b;
            pre = state;
            b = (!pressed && pre == 3'd3);
            if (b) pressed = 1;
            step(((i % 4) == 3), b);
            if (pre == 3'd5 && state != 3'd5 && !first_exit_seen) begin
                first_exit_seen = 1;
                first_exit = state;
            end
            if (pressed && !first_exit_seen && (state == 3'd4 || state == 3'd5)) begin
                checks++;
                if (req_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL req_held got %b exp 1", req_pending);
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL walk_press_seq t=%0t got %h exp %h", $time, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (first_exit !== 3'd1) begin
            errors++;
            $display("FAIL recover_requeue got %0d exp 1", first_exit);
        end
    endtask

    task automatic test_press_steady_y();
        bit pressed;
        pressed = 0;
        step(1'b0, 1'b1);
        for (int i = 0; i < 47 * 4; i++) begin
            logic b;
            b = (!pressed && state == 3'd2);
            if (b) pressed = 1;
            step(((i % 4) == 3), b);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL yellow_press_seq t=%0t got %h exp %h", $time, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (state !== 3'd0 || req_pending !== 1'b0 || !pressed) begin
            errors++;
            $display("FAIL yellow_ignored got st=%0d req=%b pressed=%b exp st=0 req=0 pressed=1",
                     state, req_pending, pressed);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        step(1'b0, 1'b1);
        while (state != 3'd4 && guard < 300) begin
            step(((guard % 4) == 3), (guard == 40));
            guard++;
        end
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL reach_alt_r got %0d exp 4", state);
        end
        @(negedge clk);
        tick = 1'b0;
        ped_btn = 1'b0;
        #2 reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step(((i % 4) == 3), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL no_resume t=%0t got %h exp %h", $time, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_seq t=%0t got %h exp %h", $time, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_same_cycle();
        test_press_steady_r();
        test_press_steady_y();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hawk_beacon_sequencer.md
HAWK_BEACON_SEQUENCER -- requirements
Module: hawk_beacon_sequencer

Interface
REQ-001 Parameter T_FY, default 4, flashing-yellow duration in ticks (1..31).
REQ-002 Parameter T_SY, default 3, steady-yellow duration in ticks (1..31).
REQ-003 Parameter T_WALK, default 7, steady-red/walk duration in ticks (1..31).
REQ-004 Parameter T_CLR, default 10, alternating-red/pedestrian-clearance duration in ticks (1..31).
REQ-005 Parameter T_REC, default 20, post-crossing recovery (dark) duration in ticks (1..31).
REQ-006 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 tick  in  1  one-clk-wide time-base enable pulse; all timing counts ticks.
REQ-009 ped_btn  in  1  pedestrian push-button level, sampled every clk.
REQ-010 y_lamp  out  1  yellow lens.
REQ-011 r_left, r_right  out  1 each  left and right red lenses.
REQ-012 walk  out  1  pedestrian WALK indication.
REQ-013 dnw  out  1  pedestrian DON'T WALK indication.
REQ-014 busy  out  1  high in every state except DARK.
REQ-015 req_pending  out  1  latched, not-yet-served crossing request.
REQ-016 countdown  out  5  remaining clearance ticks.
REQ-017 state  out  3  encoded present state: DARK=0, FLASH_Y=1, STEADY_Y=2, STEADY_R=3, ALT_R=4, RECOVER=5.

Function
REQ-018 All outputs are registered and update on the same clk edge as the state register.
REQ-019 5-bit timer; on entry to a timed state it loads that state's T_x value.
REQ-020 In a timed state, on tick: timer==1 -> transition to next state; otherwise timer decrements by 1; no tick -> hold.
REQ-021 Sequence: FLASH_Y -> STEADY_Y -> STEADY_R -> ALT_R -> RECOVER; each occupies exactly T_x ticks.
REQ-022 DARK -> FLASH_Y on a tick when req_pending==1 or ped_btn==1; otherwise DARK holds.
REQ-023 RECOVER expiry: -> FLASH_Y if request pending (including ped_btn that cycle), else -> DARK.
REQ-024 ped_btn==1 in DARK, STEADY_R, ALT_R or RECOVER sets req_pending; presses in FLASH_Y or STEADY_Y are ignored.
REQ-025 req_pending clears on the edge that enters FLASH_Y; a press in that same cycle is absorbed, not re-queued.
REQ-026 flash bit: set to 1 on entry to FLASH_Y or ALT_R; toggles on each tick that does not cause a transition.
REQ-027 DARK/RECOVER: lamps off, walk=0, dnw=1.
REQ-028 FLASH_Y: y_lamp=flash, reds off, walk=0, dnw=1.
REQ-029 STEADY_Y: y_lamp=1, reds off, walk=0, dnw=1.
REQ-030 STEADY_R: r_left=r_right=1, y_lamp=0, walk=1, dnw=0.
REQ-031 ALT_R: r_left=flash, r_right=~flash, y_lamp=0, walk=0, dnw=flash.
REQ-032 Illegal state codes 6/7 -> DARK on the next clk edge.

Reset
REQ-033 reset low forces, asynchronously: state DARK, timer 0, flash 0, req_pending 0, all lamps 0, walk 0, dnw 1, busy 0, countdown 0.
REQ-034 Reset asserted mid-sequence aborts immediately and discards any pending request; no resumption.

Configuration
REQ-035 With HAWK_COUNTDOWN_EN defined: countdown = timer in ALT_R (T_CLR down to 1), 0 in all other states.
REQ-036 Without HAWK_COUNTDOWN_EN: countdown is constant 0 and no countdown logic is synthesized; all other behaviour is unchanged.

Verification (defaults, tick every 4 clk)
REQ-037 reset low mid-run -> state=0, lamps 0, walk 0, dnw 1, busy 0, req_pending 0, countdown 0.
REQ-038 1-clk ped_btn in DARK -> next tick FLASH_Y; y_lamp 1,0,1,0 over 4 ticks; STEADY_Y 3 ticks; walk=1 for 7 ticks; ALT_R 10 ticks with reds alternating; RECOVER 20 ticks; DARK after 44 ticks total.
REQ-039 ped_btn and tick in the same clk in DARK -> FLASH_Y on that edge; req_pending stays 0.
REQ-040 Press during STEADY_R -> req_pending=1 through RECOVER; RECOVER expiry -> FLASH_Y, never DARK.
REQ-041 Press during STEADY_Y -> ignored; sequence ends in DARK with req_pending=0.
REQ-042 HAWK_COUNTDOWN_EN defined -> countdown 10,9,...,1 across ALT_R; undefined -> countdown 0 throughout.
